mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: ROM-to-RAM transfer engine with a 2-deep word FIFO.
// The initiator pushes ROM words with read_rom and pops them into RAM with
// write_ram. The block finishes after eight completed RAM writes.
// Optional feature macro: XFER_BYPASS_EN. When it is defined, a same-cycle
// read and write at an empty FIFO moves the ROM word straight into RAM.
module mem_responder (
    input  logic       clk,
    input  logic       rst,
    input  logic       read_rom,
    input  logic [2:0] rom_addr,
    input  logic       write_ram,
    input  logic [2:0] ram_addr,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [1:0] fifo_level,
    output logic [3:0] xfer_count,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic       underflow
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] fifo_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] level_q, level_d;
    logic [3:0] xfer_q, xfer_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic [7:0] ram_q [8];
    logic [7:0] rd_data_q;

    logic       push_en;
    logic       pop_en;
    logic       bypass;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] rom_word;

    // Fixed ROM contents: word i holds 8'h11 * (i + 1).
    function automatic logic [7:0] rom_lookup(input logic [2:0] a);
        logic [7:0] w;
        case (a)
            3'd0:    w = 8'h11;
            3'd1:    w = 8'h22;
            3'd2:    w = 8'h33;
            3'd3:    w = 8'h44;
            3'd4:    w = 8'h55;
            3'd5:    w = 8'h66;
            3'd6:    w = 8'h77;
            default: w = 8'h88;
        endcase
        return w;
    endfunction

    // Next-state, FIFO handshake and flag decisions.
    always_comb begin
        rom_word  = rom_lookup(rom_addr);
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        xfer_d    = xfer_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        push_en   = 1'b0;
        pop_en    = 1'b0;
        bypass    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = fifo_q[rd_ptr_q];

        case (state_q)
            ST_IDLE: begin
                // The starting read also delivers its word; writes are ignored here.
                if (read_rom) begin
                    state_d = ST_ACTIVE;
                    push_en = 1'b1;
                end
            end
            ST_ACTIVE: begin
`ifdef XFER_BYPASS_EN
                bypass = read_rom && write_ram && (level_q == 2'd0);
`else
                bypass = 1'b0;
`endif
                if (bypass) begin
                    ram_we    = 1'b1;
                    ram_wdata = rom_word;
                end else begin
                    pop_en = write_ram && (level_q != 2'd0);
                    if (write_ram && (level_q == 2'd0)) begin
                        unf_d = 1'b1;
                    end
                    // A full FIFO still accepts a push when the head leaves this cycle.
                    if (read_rom) begin
                        if ((level_q == 2'd2) && !pop_en) begin
                            ovf_d = 1'b1;
                        end else begin
                            push_en = 1'b1;
                        end
                    end
                    ram_we = pop_en;
                end
            end
            default: begin
                // DONE: everything frozen until reset.
            end
        endcase

        if (push_en) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_en) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        level_d = level_q + {1'b0, push_en} - {1'b0, pop_en};
        if (ram_we) begin
            xfer_d = xfer_q + 4'd1;
        end
        if ((state_q == ST_ACTIVE) && (xfer_d == 4'd8)) begin
            state_d = ST_DONE;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            level_q  <= 2'd0;
            xfer_q   <= 4'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            xfer_q   <= xfer_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // FIFO storage; stale words are harmless because the pointers reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_q[wr_ptr_q] <= rom_word;
        end
    end

    // RAM array: cleared on reset, written by pops or by the bypass path.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                ram_q[i] <= 8'h00;
            end
        end else if (ram_we) begin
            ram_q[ram_addr] <= ram_wdata;
        end
    end

    // Registered debug readback of the RAM contents held before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= ram_q[rd_addr];
        end
    end

    assign rd_data    = rd_data_q;
    assign fifo_level = level_q;
    assign xfer_count = xfer_q;
    assign busy       = (state_q == ST_ACTIVE);
    assign done       = (state_q == ST_DONE);
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scenarios plus randomized traffic, each cycle
// compared against a queue-based behavioural model of the transfer engine.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       read_rom = 1'b0;
    logic [2:0] rom_addr = 3'd0;
    logic       write_ram = 1'b0;
    logic [2:0] ram_addr = 3'd0;
    logic [2:0] rd_addr = 3'd0;
    logic [7:0] rd_data;
    logic [1:0] fifo_level;
    logic [3:0] xfer_count;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: mode 0 idle, 1 active, 2 done.
    int         m_mode;
    logic [7:0] m_ram [8];
    logic [7:0] m_fifo [$];
    int         m_cnt;
    bit         m_ovf;
    bit         m_unf;

    mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .read_rom   (read_rom),
        .rom_addr   (rom_addr),
        .write_ram  (write_ram),
        .ram_addr   (ram_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .fifo_level (fifo_level),
        .xfer_count (xfer_count),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic void model_reset();
        m_mode = 0;
        m_fifo.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int i = 0; i < 8; i++) m_ram[i] = 8'h00;
    endfunction

    function automatic void model_step(input bit r, input int ra, input bit w, input int wa);
        logic [7:0] word;
        bit can_pop;
        bit do_push;
        bit byp;
        word    = 8'(8'h11 * (ra + 1));
        do_push = 1'b0;
        byp     = 1'b0;
        if (m_mode == 0) begin
            if (r) begin
                m_fifo.push_back(word);
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            can_pop = w && (m_fifo.size() > 0);
`ifdef XFER_BYPASS_EN
            byp = r && w && (m_fifo.size() == 0);
`endif
            if (byp) begin
                m_ram[wa] = word;
                m_cnt++;
            end else begin
                if (w && m_fifo.size() == 0) m_unf = 1'b1;
                if (r) begin
                    if (m_fifo.size() == 2 && !can_pop) m_ovf = 1'b1;
                    else do_push = 1'b1;
                end
                if (can_pop) begin
                    m_ram[wa] = m_fifo.pop_front();
                    m_cnt++;
                end
                if (do_push) m_fifo.push_back(word);
            end
            if (m_cnt == 8) m_mode = 2;
        end
    endfunction

    // One clock: drive on the falling edge, compare just after the rising edge.
    task automatic cycle(input string tag, input bit r_rst, input bit r, input int ra,
                         input bit w, input int wa, input int rda);
        logic [7:0] exp_rd;
        @(negedge clk);
        rst       = r_rst;
        read_rom  = r;
        rom_addr  = ra[2:0];
        write_ram = w;
        ram_addr  = wa[2:0];
        rd_addr   = rda[2:0];
        exp_rd = r_rst ? 8'h00 : m_ram[rda];
        if (r_rst) model_reset();
        else model_step(r, ra, w, wa);
        @(posedge clk);
        #1;
        check({tag, "_rd"},   {24'd0, rd_data},    {24'd0, exp_rd});
        check({tag, "_lvl"},  {30'd0, fifo_level}, m_fifo.size());
        check({tag, "_cnt"},  {28'd0, xfer_count}, m_cnt);
        check({tag, "_busy"}, {31'd0, busy},       (m_mode == 1) ? 1 : 0);
        check({tag, "_done"}, {31'd0, done},       (m_mode == 2) ? 1 : 0);
        check({tag, "_ovf"},  {31'd0, overflow},   {31'd0, m_ovf});
        check({tag, "_unf"},  {31'd0, underflow},  {31'd0, m_unf});
    endtask

    task automatic idle(input string tag, input int rda);
        cycle(tag, 1'b0, 1'b0, 0, 1'b0, 0, rda);
    endtask

    // Reads one RAM word back and also compares it to a literal value.
    task automatic readback(input string tag, input int addr, input logic [7:0] exp);
        idle(tag, addr);
        check({tag, "_lit"}, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic dump_ram(input string tag);
        for (int i = 0; i < 8; i++) idle($sformatf("%s_a%0d", tag, i), i);
    endtask

    task automatic do_reset(input string tag);
        cycle(tag, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic full_sequence(input string tag);
        for (int i = 0; i < 8; i++) begin
            cycle($sformatf("%s_r%0d", tag, i), 1'b0, 1'b1, i, 1'b0, 0, 0);
            cycle($sformatf("%s_w%0d", tag, i), 1'b0, 1'b0, 0, 1'b1, i, 0);
        end
    endtask

    initial begin
        model_reset();

        // Reset state.
        do_reset("rst0");
        check("rst0_level_lit", {30'd0, fifo_level}, 0);
        dump_ram("rst0_ram");

        // Eight read/write pairs fill RAM with the ROM table.
        full_sequence("seq");
        check("seq_done_lit", {31'd0, done}, 1);
        check("seq_cnt_lit", {28'd0, xfer_count}, 8);
        for (int i = 0; i < 8; i++)
            readback($sformatf("seq_ram%0d", i), i, 8'(8'h11 * (i + 1)));

        // DONE ignores requests.
        cycle("done_ign", 1'b0, 1'b1, 0, 1'b1, 0, 0);
        readback("done_ram0", 0, 8'h11);

        // Overflow on third push, then FIFO order.
        do_reset("ovf_rst");
        cycle("ovf_p2", 1'b0, 1'b1, 2, 1'b0, 0, 0);
        cycle("ovf_p5", 1'b0, 1'b1, 5, 1'b0, 0, 0);
        cycle("ovf_p7", 1'b0, 1'b1, 7, 1'b0, 0, 0);
        check("ovf_flag_lit", {31'd0, overflow}, 1);
        cycle("ovf_w0", 1'b0, 1'b0, 0, 1'b1, 0, 0);
        cycle("ovf_w1", 1'b0, 1'b0, 0, 1'b1, 1, 0);
        readback("ovf_ram0", 0, 8'h33);
        readback("ovf_ram1", 1, 8'h66);

        // Underflow on a second write with the FIFO empty.
        do_reset("unf_rst");
        cycle("unf_p5", 1'b0, 1'b1, 5, 1'b0, 0, 0);
        cycle("unf_w3a", 1'b0, 1'b0, 0, 1'b1, 3, 0);
        cycle("unf_w3b", 1'b0, 1'b0, 0, 1'b1, 3, 0);
        check("unf_flag_lit", {31'd0, underflow}, 1);
        readback("unf_ram3", 3, 8'h66);

        // Simultaneous read and write at an empty FIFO.
        do_reset("sim_rst");
        cycle("sim_p0", 1'b0, 1'b1, 0, 1'b0, 0, 0);
        cycle("sim_w1", 1'b0, 1'b0, 0, 1'b1, 1, 0);
        cycle("sim_rw", 1'b0, 1'b1, 4, 1'b1, 6, 0);
`ifdef XFER_BYPASS_EN
        readback("sim_ram6", 6, 8'h55);
`else
        readback("sim_ram6", 6, 8'h00);
`endif

        // Reset mid-transfer with a word in flight, then repeat.
        do_reset("mid_rst0");
        for (int i = 0; i < 4; i++) begin
            cycle($sformatf("mid_r%0d", i), 1'b0, 1'b1, i, 1'b0, 0, 0);
            cycle($sformatf("mid_w%0d", i), 1'b0, 1'b0, 0, 1'b1, i, 0);
        end
        cycle("mid_push", 1'b0, 1'b1, 4, 1'b0, 0, 0);
        cycle("mid_rst", 1'b1, 1'b1, 1, 1'b1, 1, 0);
        check("mid_busy_lit", {31'd0, busy}, 0);
        dump_ram("mid_ram");
        full_sequence("rep");
        dump_ram("rep_ram");

        // Randomized traffic with occasional resets.
        do_reset("rnd_rst");
        for (int n = 0; n < 1500; n++) begin
            cycle("rnd", ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7), $urandom_range(0, 7));
        end
        dump_ram("rnd_ram");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
